// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit.
// Op encodings follow RV32M funct3.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN_DEFAULT-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division iteration on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and trial-subtracts.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quot_nxt
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem, quot[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // rem < divisor, so the top bit of diff is a clean borrow flag
  assign rem_nxt  = diff[XLEN] ? shifted[XLEN-1:0]
                               : diff[XLEN-1:0];
  assign quot_nxt = {quot[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide, one bit per cycle.
// Define MDU_DIV_EN to build the divider; without it ops 4-7 return 0.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] O
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN =
    {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] mcand;

  logic            a_sgn;
  logic            b_sgn;
  logic            neg_in;
  logic [XLEN-1:0] ma;
  logic [XLEN-1:0] mb;
  logic            special;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] hi_n;
  logic [XLEN-1:0] lo_n;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] res;

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = A[XLEN-1];
        b_sgn = B[XLEN-1];
      end
      OP_MULHSU: a_sgn = A[XLEN-1];
      default: ;
    endcase
  end

  // remainder takes the dividend's sign only
  assign neg_in = (op == OP_REM) ? a_sgn
                                 : a_sgn ^ b_sgn;
  assign ma = a_sgn ? -A : A;
  assign mb = b_sgn ? -B : B;

  always_comb begin
    special  = 1'b0;
    spec_res = '0;
`ifdef MDU_DIV_EN
    if (op[2]) begin
      if (B == '0) begin
        special  = 1'b1;
        spec_res = op[1] ? A : XLEN'(DIV0_QUOT);
      end else if (!op[0] && A == SMIN &&
                   B == '1) begin
        special  = 1'b1;
        spec_res = op[1] ? '0 : SMIN;
      end
    end
`else
    special = op[2];
`endif
  end

  // shift/add: product lives in {hi, lo}, multiplier drains from lo
  assign sum = {1'b0, hi} +
               (lo[0] ? {1'b0, mcand} : '0);

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] d_rem;
  logic [XLEN-1:0] d_quot;
  logic [XLEN-1:0] q_s;
  logic [XLEN-1:0] r_s;

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem     (hi),
    .quot    (lo),
    .divisor (mcand),
    .rem_nxt (d_rem),
    .quot_nxt(d_quot)
  );

  assign hi_n = op_q[2] ? d_rem
                        : sum[XLEN:1];
  assign lo_n = op_q[2] ? d_quot
                        : {sum[0], lo[XLEN-1:1]};
  assign q_s  = neg_q ? -lo_n : lo_n;
  assign r_s  = neg_q ? -hi_n : hi_n;
`else
  assign hi_n = sum[XLEN:1];
  assign lo_n = {sum[0], lo[XLEN-1:1]};
`endif

  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    res = prod_s[2*XLEN-1:XLEN];
    unique case (1'b1)
      (op_q == OP_MUL): res = prod_s[XLEN-1:0];
`ifdef MDU_DIV_EN
      (op_q[2] && !op_q[1]): res = q_s;
      (op_q[2] &&  op_q[1]): res = r_s;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      O     <= '0;
    end else begin
      unique case (state)
        S_CALC: begin
          hi    <= hi_n;
          lo    <= lo_n;
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= S_DONE;
            O     <= res;
          end
        end
        default: begin
          if (start) begin
            op_q  <= op;
            neg_q <= neg_in;
            if (special) begin
              state <= S_DONE;
              O     <= spec_res;
            end else begin
              state <= S_CALC;
              count <= '0;
              hi    <= '0;
              lo    <= op[2] ? ma : mb;
              mcand <= op[2] ? mb : ma;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: table-driven scoreboard bench for mdu_iter.
// Expectations for ops 4-7 follow the MDU_DIV_EN build setting.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int BOUND = 40;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] O;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  vec_t tab[20];

  mdu_iter #(.XLEN(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .O    (O)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] o,
                              logic [W-1:0] a,
                              logic [W-1:0] b,
                              logic [W-1:0] r,
                              int l);
    vec_t v;
    v.op = o;
    v.a = a;
    v.b = b;
`ifdef MDU_DIV_EN
    v.res = r;
    v.lat = l;
`else
    v.res = o[2] ? '0 : r;
    v.lat = o[2] ? 1 : l;
`endif
    return v;
  endfunction

  task automatic drive(input logic [2:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] r,
                       input int l);
    exp_t e;
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    e.res = r;
    e.lat = l;
    sb.push_back(e);
  endtask

  // Counts edges from the accept edge until done; inj>0 fires a stray start
  task automatic collect(input string name,
                         input int inj);
    int n;
    exp_t e;
    n = 0;
    while (n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 || n == inj + 1) begin
        start = 1'b0;
        op = 3'($urandom);
        A = $urandom;
        B = $urandom;
      end
      if (done) break;
      if (n == inj) begin
        start = 1'b1;
        op = OP_DIVU;
        A = 32'd1000;
        B = 32'd3;
      end
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".res"}, O, e.res);
      chk({name, ".lat"}, W'(n), W'(e.lat));
    end
  endtask

  task automatic count_done(input int cycles,
                            output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    tab[0]  = mk(OP_MUL, 32'd7, 32'hFFFFFFFD,
                 32'hFFFFFFEB, 33);
    tab[1]  = mk(OP_MULHU, '1, '1, 32'hFFFFFFFE, 33);
    tab[2]  = mk(OP_MULH, '1, '1, 32'h0, 33);
    tab[3]  = mk(OP_MULHSU, '1, 32'd2,
                 32'hFFFFFFFF, 33);
    tab[4]  = mk(OP_MULH, 32'h80000000, 32'h80000000,
                 32'h40000000, 33);
    tab[5]  = mk(OP_MULHU, 32'h80000000, 32'd2,
                 32'h1, 33);
    tab[6]  = mk(OP_MUL, 32'h80000000, '1,
                 32'h80000000, 33);
    tab[7]  = mk(OP_MUL, 32'd6, 32'd7, 32'd42, 33);
    tab[8]  = mk(OP_DIV, 32'hFFFFFFEC, 32'd6,
                 32'hFFFFFFFD, 33);
    tab[9]  = mk(OP_REM, 32'hFFFFFFEC, 32'd6,
                 32'hFFFFFFFE, 33);
    tab[10] = mk(OP_DIVU, 32'd5, 32'd0, '1, 1);
    tab[11] = mk(OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    tab[12] = mk(OP_DIV, 32'h80000000, '1,
                 32'h80000000, 1);
    tab[13] = mk(OP_REM, 32'h80000000, '1, 32'h0, 1);
    tab[14] = mk(OP_DIV, 32'd100, 32'd7, 32'd14, 33);
    tab[15] = mk(OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    tab[16] = mk(OP_DIV, 32'd7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 33);
    tab[17] = mk(OP_REM, 32'd7, 32'hFFFFFFFE,
                 32'd1, 33);
    tab[18] = mk(OP_DIVU, '1, 32'd1, '1, 33);
    tab[19] = mk(OP_REM, 32'h80000000, 32'd3,
                 32'hFFFFFFFE, 33);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", W'(busy), '0);
    chk("rst.done", W'(done), '0);
    chk("rst.O", O, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      @(negedge clk);
      drive(tab[i].op, tab[i].a, tab[i].b,
            tab[i].res, tab[i].lat);
      collect($sformatf("v%0d", i), 0);
    end

    // stray start while busy must not disturb the running op
    @(negedge clk);
    drive(OP_MUL, 32'd6, 32'd7, 32'd42, 33);
    collect("ign", 5);
    count_done(BOUND, p);
    chk("ign.extra_done", W'(p), '0);
    chk("ign.busy", W'(busy), '0);

    // back-to-back: new start accepted in the done cycle
    @(negedge clk);
`ifdef MDU_DIV_EN
    drive(OP_DIVU, 32'd5, 32'd0, '1, 1);
`else
    drive(OP_DIVU, 32'd5, 32'd0, '0, 1);
`endif
    collect("b2b0", 0);
    drive(OP_MUL, 32'd6, 32'd7, 32'd42, 33);
    collect("b2b1", 0);

    // reset in the middle of an iteration
    @(negedge clk);
    start = 1'b1;
    op = OP_MUL;
    A = 32'd9;
    B = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort.busy_pre", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("abort.busy", W'(busy), '0);
    chk("abort.done", W'(done), '0);
    chk("abort.O", O, '0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(BOUND, p);
    chk("abort.no_done", W'(p), '0);
    chk("abort.O_hold", O, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
